// File: rtl/gamepad_pkg.sv
// Shared types and constants for the SNES-style gamepad serial reader:
// FSM state encoding, button bit positions and default timing parameters.
package gamepad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETTLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int CLK_DIV_DEF  = 8;
    localparam int NUM_BITS_DEF = 12;
    localparam int POLL_DIV_DEF = 50000;

endpackage

// File: rtl/gamepad_serial_reader_if.sv
// Bundle between the gamepad reader and its surroundings (pad pins + PIO side).
// master: host/pad side drives enable, pad_data; slave: reader drives the rest.
interface gamepad_serial_reader_if
    import gamepad_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF
);
    logic                enable;
    logic                pad_data;
    logic                pad_latch;
    logic                pad_clk;
    logic [NUM_BITS-1:0] buttons;
    logic                valid;
    logic                busy;

    modport master (
        output enable,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  buttons,
        input  valid,
        input  busy
    );

    modport slave (
        input  enable,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output buttons,
        output valid,
        output busy
    );
endinterface

// File: rtl/gamepad_tick_gen.sv
// Half-period timer: pulses phase_end_o on the last cycle of a CLK_DIV phase,
// or of a 2*CLK_DIV phase when long_phase_i is set. Ports: clk, reset_n,
// run_i (count enable, clears when low), long_phase_i, phase_end_o.
module gamepad_tick_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    input  logic long_phase_i,
    output logic phase_end_o
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] SHORT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_end_o = run_i &&
        (cnt_q == (long_phase_i ? LONG_LAST : SHORT_LAST));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run_i || phase_end_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/gamepad_serial_reader.sv
// Polls an SNES-style pad (latch/clock/data) and presents an active-high button word.
// Ports: clk, reset_n (async, active-low), bus (gamepad_serial_reader_if.slave:
// enable, pad_data in; pad_latch, pad_clk, buttons, valid, busy out).
// Option: define GAMEPAD_DEBOUNCE_EN to require two identical frames per update.
module gamepad_serial_reader
    import gamepad_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int POLL_DIV = POLL_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    gamepad_serial_reader_if.slave  bus
);
    localparam int IW        = $clog2(NUM_BITS);
    localparam int PW        = $clog2(POLL_DIV);
    localparam int FRAME_LEN = (2 * NUM_BITS + 1) * CLK_DIV + 1;
    localparam bit BACK2BACK = POLL_DIV <= FRAME_LEN;
    localparam logic [IW-1:0] LAST_BIT  = IW'(NUM_BITS - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

    state_t              state_q;
    logic [1:0]          sync_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [IW-1:0]       idx_q;
    logic [PW-1:0]       poll_q;
    logic [PW-1:0]       poll_d;
    logic                pad_latch_q;
    logic                pad_clk_q;
    logic [NUM_BITS-1:0] buttons_q;
    logic                valid_q;
    logic                busy_q;
`ifdef GAMEPAD_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev_q;
`endif

    logic sync_data;
    logic phase_end;
    logic run;
    logic go_latch;

    assign sync_data = sync_q[1];
    assign run = (state_q == LATCH) || (state_q == SETTLE) ||
                 (state_q == LOW) || (state_q == HIGH);

    // The cycle that decides to start a frame is poll position 0.
    assign go_latch = bus.enable &&
        (((state_q == IDLE) && (poll_q == '0)) ||
         ((state_q == DONE) && BACK2BACK));

    always_comb begin
        poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
        if ((state_q == IDLE) && !bus.enable) poll_d = '0;
        if (go_latch) poll_d = PW'(1);
    end

    gamepad_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk          (clk),
        .reset_n      (reset_n),
        .run_i        (run),
        .long_phase_i (state_q == LATCH),
        .phase_end_o  (phase_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            shift_q     <= '0;
            idx_q       <= '0;
            poll_q      <= '0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            buttons_q   <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
            prev_q      <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            poll_q  <= poll_d;
            sync_q  <= {sync_q[0], bus.pad_data};
            unique case (state_q)
                IDLE: begin
                    if (go_latch) begin
                        state_q     <= LATCH;
                        pad_latch_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        state_q     <= SETTLE;
                        pad_latch_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (phase_end) begin
                        shift_q[0] <= sync_data;
                        idx_q      <= IW'(1);
                        state_q    <= LOW;
                        pad_clk_q  <= 1'b0;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state_q   <= HIGH;
                        pad_clk_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        shift_q[idx_q] <= sync_data;
                        if (idx_q == LAST_BIT) begin
                            state_q <= DONE;
                        end else begin
                            idx_q     <= idx_q + IW'(1);
                            state_q   <= LOW;
                            pad_clk_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
`ifdef GAMEPAD_DEBOUNCE_EN
                    if (~shift_q == prev_q) begin
                        buttons_q <= ~shift_q;
                        valid_q   <= 1'b1;
                    end
                    prev_q <= ~shift_q;
`else
                    buttons_q <= ~shift_q;
                    valid_q   <= 1'b1;
`endif
                    idx_q <= '0;
                    if (go_latch) begin
                        state_q     <= LATCH;
                        pad_latch_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pad_latch = pad_latch_q;
    assign bus.pad_clk   = pad_clk_q;
    assign bus.buttons   = buttons_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_gamepad_serial_reader.sv
// Self-checking bench for gamepad_serial_reader with a shift-register pad model
// and a frame-level reference model of the button word.
module tb_gamepad_serial_reader;
    localparam int NB = 12;

`ifdef GAMEPAD_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    gamepad_serial_reader_if #(.NUM_BITS(NB)) bus ();

    gamepad_serial_reader #(
        .CLK_DIV  (4),
        .NUM_BITS (NB),
        .POLL_DIV (200)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int starts = 0;
    int last_start = 0;
    int prev_start = 0;
    int lows = 0;
    int busy_n = 0;
    int n_tests = 0;
    int n_fail = 0;
    int gmode = 0;
    logic latch_p = 1'b0;
    logic clk_p = 1'b1;
    logic ovr = 1'b1;
    logic [NB-1:0] pad_vec = '1;
    logic [NB-1:0] pad_sr = '1;
    logic [NB-1:0] m_btn = '0;
    logic [NB-1:0] m_prev = '0;
    bit m_valid = 1'b0;

    // Pad: loads its button vector while latched, shifts LSB-first on pad_clk rise.
    always @(posedge bus.pad_clk or posedge bus.pad_latch) begin
        if (bus.pad_latch) pad_sr <= pad_vec;
        else               pad_sr <= {1'b1, pad_sr[NB-1:1]};
    end

    assign bus.pad_data = (gmode == 0) ? pad_sr[0] : ovr;

    // Per-cycle monitor; offset 0 is the first cycle with pad_latch high.
    always @(negedge clk) begin
        int off;
        cyc++;
        if (bus.pad_latch && !latch_p) begin
            starts++;
            prev_start = last_start;
            last_start = cyc;
            lows = 0;
            busy_n = 0;
        end
        if (!bus.pad_clk && clk_p) lows++;
        if (bus.busy) busy_n++;
        latch_p = bus.pad_latch;
        clk_p = bus.pad_clk;
        // Bit 3 window: raw data low over offsets 28..35; in mode 1 it is
        // high only at 33, whose synchronized value is what bit 3 samples.
        off = cyc - last_start;
        ovr = 1'b1;
        if (gmode != 0 && off >= 28 && off <= 35)
            ovr = (gmode == 1) && (off == 33);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_frame(input logic [NB-1:0] raw);
        logic [NB-1:0] f;
        f = ~raw;
        if (DEB) begin
            m_valid = (f == m_prev);
            if (m_valid) m_btn = f;
            m_prev = f;
        end else begin
            m_btn = f;
            m_valid = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_btn = '0;
        m_prev = '0;
        m_valid = 1'b0;
    endtask

    task automatic frame(input logic [NB-1:0] vec, input int mode,
                         input int drop_at, input int exp_start,
                         input string tag);
        int n0;
        int k;
        logic [NB-1:0] raw;
        pad_vec = vec;
        gmode = mode;
        n0 = starts;
        k = 0;
        while (starts == n0 && k < 450) begin
            @(negedge clk); #1;
            k++;
        end
        if (starts == n0) begin
            check({tag, "/start_timeout"}, 0, 1);
            return;
        end
        if (exp_start >= 0) check({tag, "/t0"}, last_start, exp_start);
        k = 0;
        while (bus.busy && k < 200) begin
            if (k == drop_at) bus.enable = 1'b0;
            @(negedge clk); #1;
            k++;
        end
        if (bus.busy) begin
            check({tag, "/end_timeout"}, 0, 1);
            return;
        end
        raw = (mode == 0) ? vec : (mode == 1) ? 12'hFFF : 12'hFF7;
        model_frame(raw);
        check({tag, "/btn"}, bus.buttons, m_btn);
        check({tag, "/valid"}, bus.valid, m_valid);
        check({tag, "/len"}, busy_n, 101);
        check({tag, "/lows"}, lows, 11);
        @(negedge clk); #1;
        check({tag, "/vpulse"}, bus.valid, 0);
    endtask

    initial begin
        int c;
        int n0;
        int k;
        reset_n = 1'b0;
        bus.enable = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst/latch", bus.pad_latch, 0);
        check("rst/pclk", bus.pad_clk, 1);
        check("rst/btn", bus.buttons, 0);
        check("rst/valid", bus.valid, 0);
        check("rst/busy", bus.busy, 0);

        c = cyc;
        bus.enable = 1'b1;
        reset_n = 1'b1;
        frame(12'hFFE, 0, -1, c + 1, "b_only");

        frame(12'hFFF, 0, -1, -1, "none_a");
        frame(12'hFFF, 0, -1, -1, "none_b");
        check("period", last_start - prev_start, 200);

        for (int i = 0; i < 6; i++)
            frame(12'($urandom), 0, -1, -1, $sformatf("rnd%0d", i));

        frame(12'h7FF, 0, -1, -1, "r_a");
        frame(12'hFFF, 0, -1, -1, "r_rel");
        frame(12'h7FF, 0, -1, -1, "r_b");
        frame(12'h7FF, 0, -1, -1, "r_c");

        frame(12'hFFF, 2, -1, -1, "start_low");
        frame(12'hFFF, 1, -1, -1, "glitch_a");
        frame(12'hFFF, 1, -1, -1, "glitch_b");

        frame(12'($urandom), 0, 20, -1, "en_drop");
        n0 = starts;
        repeat (300) @(negedge clk);
        #1;
        check("hold/starts", starts - n0, 0);
        check("hold/busy", bus.busy, 0);
        check("hold/latch", bus.pad_latch, 0);
        @(negedge clk); #1;
        c = cyc;
        bus.enable = 1'b1;
        frame(12'hFFE, 0, -1, c + 1, "en_re_a");
        frame(12'hFFE, 0, -1, -1, "en_re_b");

        pad_vec = 12'h0F0;
        n0 = starts;
        k = 0;
        while (starts == n0 && k < 450) begin
            @(negedge clk); #1;
            k++;
        end
        check("mid/started", starts - n0, 1);
        repeat (30) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid/pclk", bus.pad_clk, 1);
        check("mid/latch", bus.pad_latch, 0);
        check("mid/btn", bus.buttons, 0);
        check("mid/busy", bus.busy, 0);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        c = cyc;
        reset_n = 1'b1;
        frame(12'hFFE, 0, -1, c + 1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
